// File: rtl/pos_integrator_pkg.sv
// Shared state encoding, heading constants and rounding helper for the odometry integrator.
package pos_integrator_pkg;

  typedef enum logic [2:0] {IDLE, CAPT, MUL, ACC, WRAP} state_e;

  localparam int unsigned DEF_FRACTIONAL_Q = 15;
  localparam int unsigned DEF_GUARD_G      = 16;
  localparam int unsigned DEF_ACC_FRAC     = DEF_FRACTIONAL_Q + DEF_GUARD_G;
  localparam int unsigned RS_W             = 128;

  localparam longint THETA_180_FX = longint'(180) <<< DEF_ACC_FRAC;
  localparam longint THETA_360_FX = longint'(360) <<< DEF_ACC_FRAC;

  // Rescale an integer-degree heading constant to another accumulator fraction width.
  function automatic longint theta_const(input longint c_def, input int unsigned frac_bits);
    if (frac_bits >= DEF_ACC_FRAC) return c_def <<< (frac_bits - DEF_ACC_FRAC);
    return c_def >>> (DEF_ACC_FRAC - frac_bits);
  endfunction

  function automatic logic signed [RS_W-1:0] rshift_round(input logic signed [RS_W-1:0] x,
                                                          input int unsigned sh);
    logic signed [RS_W-1:0] half;
    half = (sh == 0) ? '0 : (RS_W'(1) << (sh - 1));
    return (x + half) >>> sh;
  endfunction

endpackage

// File: rtl/fx_mul_round.sv
// Registered signed N x N multiply followed by a round-half-up arithmetic right shift.
module fx_mul_round
  import pos_integrator_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned SHIFT = 14,
  parameter int unsigned OUT_W = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [N-1:0]     a_i,
  input  logic signed [N-1:0]     k_i,
  output logic signed [OUT_W-1:0] p_q
);

  localparam int unsigned PW = 2 * N;

  logic signed [PW-1:0]    prod;
  logic signed [RS_W-1:0]  prod_ext;
  logic signed [OUT_W-1:0] p_d;

  always_comb begin
    prod     = $signed(PW'(a_i)) * $signed(PW'(k_i));
    prod_ext = RS_W'(prod);
    p_d      = p_q;
    if (en) p_d = OUT_W'(rshift_round(prod_ext, SHIFT));
  end

  always_ff @(posedge clk) begin
    if (rst) p_q <= '0;
    else     p_q <= p_d;
  end

endmodule

// File: rtl/pos_integrator.sv
// Odometry integrator: samples global velocities each tick and accumulates X/Y and heading.
// Define POS_INTEGRATOR_SAT_EN to clamp X/Y on overflow (sticky SAT) instead of wrapping.
module pos_integrator
  import pos_integrator_pkg::*;
#(
  parameter int unsigned DATAWIDTH_N  = 32,
  parameter int unsigned FRACTIONAL_Q = DEF_FRACTIONAL_Q,
  parameter int unsigned GUARD_G      = DEF_GUARD_G,
  parameter int unsigned TICK_CYCLES  = 50000,
  parameter int unsigned DT_Q         = 30,
  parameter int unsigned DT_FX        = 1073742,
  parameter int unsigned KTH_FX       = 61520877
) (
  input  logic                   POS_INTEGRATOR_CLOCK_50,
  input  logic                   POS_INTEGRATOR_Reset_InHigh,
  input  logic                   POS_INTEGRATOR_ENABLE_InHigh,
  input  logic                   POS_INTEGRATOR_SETBEGIN_InLow,
  input  logic [DATAWIDTH_N-1:0] POS_INTEGRATOR_PRESETX_InBus,
  input  logic [DATAWIDTH_N-1:0] POS_INTEGRATOR_PRESETY_InBus,
  input  logic [DATAWIDTH_N-1:0] POS_INTEGRATOR_PRESETTH_InBus,
  input  logic [DATAWIDTH_N-1:0] POS_INTEGRATOR_VX_InBus,
  input  logic [DATAWIDTH_N-1:0] POS_INTEGRATOR_VY_InBus,
  input  logic [DATAWIDTH_N-1:0] POS_INTEGRATOR_WZ_InBus,
  output logic [DATAWIDTH_N-1:0] POS_INTEGRATOR_POSX_OutBus,
  output logic [DATAWIDTH_N-1:0] POS_INTEGRATOR_POSY_OutBus,
  output logic [DATAWIDTH_N-1:0] POS_INTEGRATOR_THETA_OutBus,
  output logic                   POS_INTEGRATOR_VALID_OutHigh,
  output logic                   POS_INTEGRATOR_SAT_OutHigh
);

  localparam int unsigned N     = DATAWIDTH_N;
  localparam int unsigned AW    = N + GUARD_G;
  localparam int unsigned SHIFT = DT_Q - GUARD_G;
  localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic signed [N-1:0]  DT_K     = N'(DT_FX);
  localparam logic signed [N-1:0]  KTH_K    = N'(KTH_FX);
  localparam logic signed [AW-1:0] TH_180   = AW'(theta_const(THETA_180_FX, FRACTIONAL_Q + GUARD_G));
  localparam logic signed [AW-1:0] TH_360   = AW'(theta_const(THETA_360_FX, FRACTIONAL_Q + GUARD_G));

`ifdef POS_INTEGRATOR_SAT_EN
  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  function automatic logic add_ovf(input logic signed [AW-1:0] a, input logic signed [AW-1:0] b);
    logic signed [AW:0] s;
    s = (AW+1)'(a) + (AW+1)'(b);
    return s[AW] != s[AW-1];
  endfunction

  function automatic logic signed [AW-1:0] clamp_add(input logic signed [AW-1:0] a,
                                                     input logic signed [AW-1:0] b);
    logic signed [AW:0] s;
    s = (AW+1)'(a) + (AW+1)'(b);
    if (s[AW] != s[AW-1]) return s[AW] ? ACC_MIN : ACC_MAX;
    return s[AW-1:0];
  endfunction
`endif

  logic clk;
  logic rst;
  logic enable;
  logic setbegin_n;

  assign clk        = POS_INTEGRATOR_CLOCK_50;
  assign rst        = POS_INTEGRATOR_Reset_InHigh;
  assign enable     = POS_INTEGRATOR_ENABLE_InHigh;
  assign setbegin_n = POS_INTEGRATOR_SETBEGIN_InLow;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic signed [N-1:0]   vx_q, vx_d, vy_q, vy_d, wz_q, wz_d;
  logic signed [AW-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d, acc_th_q, acc_th_d;
  logic [N-1:0]          pos_x_q, pos_x_d, pos_y_q, pos_y_d, theta_q, theta_d;
  logic                  valid_q, valid_d, sat_q, sat_d, upd_q, upd_d, load_q, load_d;
  logic signed [AW-1:0]  prod_x, prod_y, prod_th;
  logic                  mul_en;
  logic                  tc;

  assign tc = enable && (cnt_q == CNT_LAST);

  fx_mul_round #(.N(N), .SHIFT(SHIFT), .OUT_W(AW)) u_mul_x (
    .clk(clk), .rst(rst), .en(mul_en), .a_i(vx_q), .k_i(DT_K), .p_q(prod_x)
  );
  fx_mul_round #(.N(N), .SHIFT(SHIFT), .OUT_W(AW)) u_mul_y (
    .clk(clk), .rst(rst), .en(mul_en), .a_i(vy_q), .k_i(DT_K), .p_q(prod_y)
  );
  fx_mul_round #(.N(N), .SHIFT(SHIFT), .OUT_W(AW)) u_mul_th (
    .clk(clk), .rst(rst), .en(mul_en), .a_i(wz_q), .k_i(KTH_K), .p_q(prod_th)
  );

  // Step sequencer, accumulators and output staging; preset load overrides everything but reset.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    wz_d     = wz_q;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    acc_th_d = acc_th_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    theta_d  = theta_q;
    sat_d    = sat_q;
    upd_d    = 1'b0;
    load_d   = 1'b0;
    valid_d  = upd_q;
    mul_en   = 1'b0;

    if (enable) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: if (tc) state_d = CAPT;
      CAPT: begin
        vx_d    = POS_INTEGRATOR_VX_InBus;
        vy_d    = POS_INTEGRATOR_VY_InBus;
        wz_d    = POS_INTEGRATOR_WZ_InBus;
        state_d = MUL;
      end
      MUL: begin
        mul_en  = 1'b1;
        state_d = ACC;
      end
      ACC: begin
`ifdef POS_INTEGRATOR_SAT_EN
        acc_x_d = clamp_add(acc_x_q, prod_x);
        acc_y_d = clamp_add(acc_y_q, prod_y);
        if (add_ovf(acc_x_q, prod_x) || add_ovf(acc_y_q, prod_y)) sat_d = 1'b1;
`else
        acc_x_d = acc_x_q + prod_x;
        acc_y_d = acc_y_q + prod_y;
`endif
        acc_th_d = acc_th_q + prod_th;
        state_d  = WRAP;
      end
      WRAP: begin
        if (acc_th_q >= TH_180)      acc_th_d = acc_th_q - TH_360;
        else if (acc_th_q < -TH_180) acc_th_d = acc_th_q + TH_360;
        upd_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (upd_q || load_q) begin
      pos_x_d = acc_x_q[AW-1:GUARD_G];
      pos_y_d = acc_y_q[AW-1:GUARD_G];
      theta_d = acc_th_q[AW-1:GUARD_G];
    end

    if (!setbegin_n) begin
      acc_x_d  = {POS_INTEGRATOR_PRESETX_InBus, {GUARD_G{1'b0}}};
      acc_y_d  = {POS_INTEGRATOR_PRESETY_InBus, {GUARD_G{1'b0}}};
      acc_th_d = {POS_INTEGRATOR_PRESETTH_InBus, {GUARD_G{1'b0}}};
      cnt_d    = '0;
      state_d  = IDLE;
      sat_d    = 1'b0;
      upd_d    = 1'b0;
      valid_d  = 1'b0;
      load_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      wz_q     <= '0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      acc_th_q <= '0;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      theta_q  <= '0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
      upd_q    <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      wz_q     <= wz_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      acc_th_q <= acc_th_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      theta_q  <= theta_d;
      valid_q  <= valid_d;
      sat_q    <= sat_d;
      upd_q    <= upd_d;
      load_q   <= load_d;
    end
  end

  assign POS_INTEGRATOR_POSX_OutBus   = pos_x_q;
  assign POS_INTEGRATOR_POSY_OutBus   = pos_y_q;
  assign POS_INTEGRATOR_THETA_OutBus  = theta_q;
  assign POS_INTEGRATOR_VALID_OutHigh = valid_q;
  assign POS_INTEGRATOR_SAT_OutHigh   = sat_q;

endmodule

// File: tb/tb_pos_integrator.sv
// Directed bench for pos_integrator with a short tick; expected values computed by hand.
module tb_pos_integrator;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst, en, setb_n;
  logic [31:0] prx, pry, prth, vx, vy, wz;
  logic [31:0] posx, posy, theta;
  logic        valid, sat;

  int checks = 0;
  int errors = 0;
  int n;
  int bad;

  always #5 clk = ~clk;

  pos_integrator #(.TICK_CYCLES(T)) dut (
    .POS_INTEGRATOR_CLOCK_50      (clk),
    .POS_INTEGRATOR_Reset_InHigh  (rst),
    .POS_INTEGRATOR_ENABLE_InHigh (en),
    .POS_INTEGRATOR_SETBEGIN_InLow(setb_n),
    .POS_INTEGRATOR_PRESETX_InBus (prx),
    .POS_INTEGRATOR_PRESETY_InBus (pry),
    .POS_INTEGRATOR_PRESETTH_InBus(prth),
    .POS_INTEGRATOR_VX_InBus      (vx),
    .POS_INTEGRATOR_VY_InBus      (vy),
    .POS_INTEGRATOR_WZ_InBus      (wz),
    .POS_INTEGRATOR_POSX_OutBus   (posx),
    .POS_INTEGRATOR_POSY_OutBus   (posy),
    .POS_INTEGRATOR_THETA_OutBus  (theta),
    .POS_INTEGRATOR_VALID_OutHigh (valid),
    .POS_INTEGRATOR_SAT_OutHigh   (sat)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Edges until VALID is seen, or -1 if the budget runs out.
  task automatic wait_valid(input int max_cyc, output int cnt);
    cnt = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      step();
      if (valid === 1'b1) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic do_preset(input logic [31:0] x, input logic [31:0] y, input logic [31:0] th);
    prx    = x;
    pry    = y;
    prth   = th;
    setb_n = 1'b0;
    step();
    setb_n = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; setb_n = 1'b1;
    prx = '0; pry = '0; prth = '0; vx = '0; vy = '0; wz = '0;
    repeat (3) step();
    chk("rst_posx", posx, 32'd0);
    chk("rst_posy", posy, 32'd0);
    chk("rst_theta", theta, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);

    rst = 1'b0; en = 1'b1;
    wait_valid(40, n);
    chk("first_valid_lat", 32'(n), 32'(T + 5));
    chk("first_posx", posx, 32'd0);

    // 1.0 m/s in X and -0.5 m/s in Y for 1000 steps of 1 ms
    vx = 32'd32768;
    vy = 32'hFFFF_C000;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      wait_valid(2 * T, n);
      if (n != int'(T)) bad++;
    end
    chk("xy_step_period", 32'(bad), 32'd0);
    chk("xy_posx", posx, 32'd32768);
    chk("xy_posy", posy, 32'hFFFF_BFFF);
    chk("xy_theta", theta, 32'd0);

    // heading wrap from 179.9 deg at 1 rad/s
    vx = '0; vy = '0; wz = 32'd32768;
    do_preset(32'd0, 32'd0, 32'd5894963);
    chk("th_preset", theta, 32'd5894963);
    chk("th_posx", posx, 32'd0);
    wait_valid(3 * T, n);
    chk("th_lat_after_preset", 32'(n), 32'(T + 4));
    chk("th_step1", theta, 32'd5896840);
    wait_valid(2 * T, n);
    chk("th_step2", theta, 32'hFFA6_01DD);
    chk("th_range", 32'(($signed(theta) < 32'sd5898240) && ($signed(theta) >= -32'sd5898240)), 32'd1);

    // preset during MUL aborts the step
    wz = '0;
    repeat (4) step();
    prx = 32'd65536; pry = '0; prth = '0;
    setb_n = 1'b0;
    step();
    chk("abort_valid_hold", 32'(valid), 32'd0);
    setb_n = 1'b1;
    step();
    chk("abort_posx", posx, 32'd65536);
    chk("abort_theta", theta, 32'd0);
    chk("abort_valid_rel", 32'(valid), 32'd0);
    wait_valid(3 * T, n);
    chk("abort_restart_lat", 32'(n + 1), 32'(T + 5));

    // counter hold while disabled
    step();
    en = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (valid !== 1'b0) bad++;
    end
    chk("en_hold_no_valid", 32'(bad), 32'd0);
    chk("en_hold_posx", posx, 32'd65536);
    en = 1'b1;
    wait_valid(3 * T, n);
    chk("en_resume_lat", 32'(n), 32'(T + 5 - 6));

    // X overflow
    vx = 32'h7FFF_FFFF;
    do_preset(32'h7FFF_0000, 32'd0, 32'd0);
    wait_valid(3 * T, n);
`ifdef POS_INTEGRATOR_SAT_EN
    chk("ovf1_posx", posx, 32'h7FFF_FFFF);
    chk("ovf1_sat", 32'(sat), 32'd1);
    wait_valid(2 * T, n);
    chk("ovf2_posx", posx, 32'h7FFF_FFFF);
    chk("ovf2_sat", 32'(sat), 32'd1);
`else
    chk("ovf1_posx", posx, 32'h801F_C49B);
    chk("ovf1_sat", 32'(sat), 32'd0);
    wait_valid(2 * T, n);
    chk("ovf2_posx", posx, 32'h8040_8937);
    chk("ovf2_sat", 32'(sat), 32'd0);
`endif
    vx = '0;
    do_preset(32'd0, 32'd0, 32'd0);
    chk("preset_sat_clr", 32'(sat), 32'd0);
    chk("preset_posx_clr", posx, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
